// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch/issue sequencer between a synchronous program ROM and
// the simple processor. Fetches an instruction word (plus the immediate word
// for mvi), drives it onto the processor din with a one-cycle run pulse, then
// waits for done before fetching the next instruction.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        pulse: begin execution at address 0 (ignored while busy)
//   stop         level: sampled on the done cycle, return to IDLE instead of fetching
//   mem_addr     ROM address, always equal to the program counter
//   mem_rdata    ROM data, valid one cycle after mem_addr
//   proc_din     processor din
//   proc_run     processor run, one-cycle pulse per instruction
//   proc_done    processor done
//   busy         high outside IDLE / HALTED / ERROR
//   halted       high in HALTED
//   err          high in ERROR (done timeout)
//   instr_count  instructions completed since start, saturating
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | pc presented on mem_addr, ROM read in flight
// LATCH     | instruction word on mem_rdata; capture it, advance pc, decode
// IMM_FETCH | mvi: immediate address presented
// IMM_LATCH | mvi: capture immediate, advance pc
// ISSUE     | run pulse with the instruction word on din
// WAIT_DONE | waiting for done (immediate on din for mvi), timeout running
// HALTED    | HALT word consumed; waiting for start
// ERROR     | done never arrived; waiting for start

module prog_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [2:0]  OP_MVI  = 3'b001,
  parameter logic [2:0]  OP_HALT = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [15:0]       instr_count
);

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT + 1);
  // Value of the timeout counter during the last permitted WAIT_DONE cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_IMM_FETCH,
    S_IMM_LATCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         imm_q, imm_d;
  logic [15:0]         din_q, din_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                instr_is_mvi;

  assign instr_is_mvi = (instr_q[8:6] == OP_MVI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // din is registered: it is loaded on the edge entering ISSUE (instruction
  // word) and on the edge entering WAIT_DONE (immediate for mvi), and holds
  // everywhere else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    din_d   = din_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end

      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        instr_d = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        if (mem_rdata[8:6] == OP_HALT) begin
          state_d = S_HALTED;
        end else if (mem_rdata[8:6] == OP_MVI) begin
          state_d = S_IMM_FETCH;
        end else begin
          state_d = S_ISSUE;
          din_d   = mem_rdata;
        end
      end

      S_IMM_FETCH: state_d = S_IMM_LATCH;

      S_IMM_LATCH: begin
        imm_d   = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        din_d   = instr_q;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        tmo_d   = '0;
        din_d   = instr_is_mvi ? imm_q : instr_q;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        tmo_d = tmo_q + CNT_W'(1);
        // done takes priority over a timeout expiring in the same cycle
        if (proc_done) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = stop ? S_IDLE : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr    = pc_q;
  assign proc_din    = din_q;
  assign proc_run    = (state_q == S_ISSUE);
  assign busy        = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR));
  assign halted      = (state_q == S_HALTED);
  assign err         = (state_q == S_ERROR);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  localparam int MAXC    = 3000;
  localparam int TIMEOUT = 16;

  localparam logic [15:0] W_MV   = 16'h0008;  // opcode 000
  localparam logic [15:0] W_MVI  = 16'h0050;  // opcode 001
  localparam logic [15:0] W_HALT = 16'h01C0;  // opcode 111
  localparam logic [15:0] W_ADD0 = 16'h0088;  // opcode 010
  localparam logic [15:0] W_ADD1 = 16'h0091;
  localparam logic [15:0] W_ADD2 = 16'h009A;
  localparam logic [15:0] W_ADD3 = 16'h00A3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, proc_done;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata, proc_din, instr_count;
  logic        proc_run, busy, halted, err;

  logic        start2, stop2, proc_done2;
  logic [1:0]  mem_addr2;
  logic [15:0] mem_rdata2, proc_din2, instr_count2;
  logic        proc_run2, busy2, halted2, err2;

  logic [15:0] rom  [256];
  logic [15:0] rom2 [4];

  prog_sequencer #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .proc_din(proc_din), .proc_run(proc_run), .proc_done(proc_done),
    .busy(busy), .halted(halted), .err(err), .instr_count(instr_count)
  );

  prog_sequencer #(.ADDR_W(2), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2),
    .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .proc_din(proc_din2), .proc_run(proc_run2), .proc_done(proc_done2),
    .busy(busy2), .halted(halted2), .err(err2), .instr_count(instr_count2)
  );

  always @(posedge clk) mem_rdata  <= rom[mem_addr];
  always @(posedge clk) mem_rdata2 <= rom2[mem_addr2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // ---------------- expected timeline (model) ----------------
  bit          e_vld  [MAXC];
  bit          e_run  [MAXC];
  bit          e_busy [MAXC];
  bit          e_halt [MAXC];
  bit          e_err  [MAXC];
  logic [15:0] e_din  [MAXC];
  logic [7:0]  e_addr [MAXC];
  logic [15:0] e_cnt  [MAXC];

  logic [15:0] m_din;     // value din holds between instructions
  int          dly;       // processor done delay after run; 0 = never
  bit          stop_lvl;

  task automatic put(input int c, input bit run, input logic [15:0] din, input logic [7:0] addr,
                     input bit bsy, input bit hlt, input bit er, input logic [15:0] cnt);
    if (c >= 0 && c < MAXC) begin
      e_vld[c] = 1'b1; e_run[c] = run; e_din[c] = din; e_addr[c] = addr;
      e_busy[c] = bsy; e_halt[c] = hlt; e_err[c] = er; e_cnt[c] = cnt;
    end
  endtask

  task automatic put_rest(input int c, input logic [15:0] din, input logic [7:0] addr,
                          input bit hlt, input bit er, input logic [15:0] cnt);
    for (int k = c; k < MAXC; k++) put(k, 1'b0, din, addr, 1'b0, hlt, er, cnt);
  endtask

  // Timeline of a program run whose first fetch cycle is t0: two cycles to
  // fetch a word, two more for an mvi immediate, run on the next cycle,
  // done dly cycles after run, next fetch the cycle after done.
  task automatic plan(input int t0);
    int t, r, p;
    logic [15:0] w, dout, cnt;
    t = t0; p = 0; cnt = 16'd0;
    while (t < MAXC) begin
      w = rom[p];
      put(t,     1'b0, m_din, 8'(p), 1'b1, 1'b0, 1'b0, cnt);
      put(t + 1, 1'b0, m_din, 8'(p), 1'b1, 1'b0, 1'b0, cnt);
      if (w[8:6] == 3'b111) begin
        put_rest(t + 2, m_din, 8'((p + 1) % 256), 1'b1, 1'b0, cnt);
        return;
      end
      if (w[8:6] == 3'b001) begin
        dout = rom[(p + 1) % 256];
        put(t + 2, 1'b0, m_din, 8'((p + 1) % 256), 1'b1, 1'b0, 1'b0, cnt);
        put(t + 3, 1'b0, m_din, 8'((p + 1) % 256), 1'b1, 1'b0, 1'b0, cnt);
        p = (p + 2) % 256;
        r = t + 4;
      end else begin
        dout = w;
        p = (p + 1) % 256;
        r = t + 2;
      end
      put(r, 1'b1, w, 8'(p), 1'b1, 1'b0, 1'b0, cnt);
      m_din = dout;
      if (dly >= 1 && dly <= TIMEOUT) begin
        for (int k = 1; k <= dly; k++) put(r + k, 1'b0, dout, 8'(p), 1'b1, 1'b0, 1'b0, cnt);
        if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
        t = r + dly + 1;
        if (stop_lvl) begin
          put_rest(t, dout, 8'(p), 1'b0, 1'b0, cnt);
          return;
        end
      end else begin
        for (int k = 1; k <= TIMEOUT; k++) put(r + k, 1'b0, dout, 8'(p), 1'b1, 1'b0, 1'b0, cnt);
        put_rest(r + TIMEOUT + 1, dout, 8'(p), 1'b0, 1'b1, cnt);
        return;
      end
    end
  endtask

  // per-cycle compare against the timeline
  always @(negedge clk) begin
    if (cyc < MAXC && e_vld[cyc]) begin
      chk("run",    32'(proc_run),    32'(e_run[cyc]));
      chk("din",    32'(proc_din),    32'(e_din[cyc]));
      chk("addr",   32'(mem_addr),    32'(e_addr[cyc]));
      chk("busy",   32'(busy),        32'(e_busy[cyc]));
      chk("halted", 32'(halted),      32'(e_halt[cyc]));
      chk("err",    32'(err),         32'(e_err[cyc]));
      chk("count",  32'(instr_count), 32'(e_cnt[cyc]));
    end
  end

  // ---------------- processor stubs ----------------
  bit pend = 0;
  int run_cyc = 0, last_done = -1, stray_cyc = -1, run_total = 0;
  int gap_log [64];

  initial begin
    proc_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      proc_done = 1'b0;
      if ((pend && dly != 0 && cyc == run_cyc + dly) || cyc == stray_cyc) begin
        proc_done = 1'b1;
        pend      = 1'b0;
        last_done = cyc;
      end
      @(negedge clk);
      if (proc_run) begin
        pend    = 1'b1;
        run_cyc = cyc;
        if (run_total < 64) gap_log[run_total] = cyc - last_done;
        run_total++;
      end
      if (reset) pend = 1'b0;
    end
  end

  bit pend2 = 0;
  int run2_cyc = 0;
  initial begin
    proc_done2 = 1'b0;
    forever begin
      @(posedge clk); #1;
      proc_done2 = 1'b0;
      if (pend2 && cyc == run2_cyc + 2) begin
        proc_done2 = 1'b1;
        pend2      = 1'b0;
      end
      @(negedge clk);
      if (proc_run2) begin
        pend2    = 1'b1;
        run2_cyc = cyc;
      end
      if (reset) pend2 = 1'b0;
    end
  end

  // ---------------- driver ----------------
  int st_cyc;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_din = 16'd0;
    put_rest(cyc + 1, 16'd0, 8'd0, 1'b0, 1'b0, 16'd0);
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    st_cyc = cyc;
    plan(cyc + 1);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_run(input int lim);
    int n;
    n = 0;
    while (!proc_run && n < lim) begin @(negedge clk); n++; end
  endtask

  task automatic wait_halted(input int lim);
    int n;
    n = 0;
    while (!halted && n < lim) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n, k, runs0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    start2 = 1'b0; stop2 = 1'b0;
    dly = 2; stop_lvl = 1'b0; m_din = 16'd0;
    for (int i = 0; i < 256; i++) rom[i] = 16'd0;
    for (int i = 0; i < 4; i++) rom2[i] = 16'd0;
    do_reset();
    @(negedge clk);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_din",   32'(proc_din), 32'd0);
    tick(2);

    // mv then HALT
    rom[0] = W_MV; rom[1] = W_HALT;
    runs0 = run_total;
    pulse_start();
    wait_run(40);
    chk("s1_run_latency", 32'(cyc - st_cyc), 32'd3);
    chk("s1_run_din",     32'(proc_din),     32'(W_MV));
    wait_halted(40);
    chk("s1_halted", 32'(halted),            32'd1);
    chk("s1_count",  32'(instr_count),       32'd1);
    chk("s1_pc",     32'(mem_addr),          32'd2);
    chk("s1_runs",   32'(run_total - runs0), 32'd1);
    tick(2);

    // mvi with immediate, then HALT
    rom[0] = W_MVI; rom[1] = 16'h00A5; rom[2] = W_HALT;
    pulse_start();
    wait_run(40);
    chk("s2_run_latency", 32'(cyc - st_cyc), 32'd5);
    chk("s2_run_din",     32'(proc_din),     32'(W_MVI));
    @(negedge clk);
    chk("s2_imm_din",     32'(proc_din),     32'h00A5);
    wait_halted(40);
    chk("s2_pc",          32'(mem_addr),     32'd3);
    tick(2);

    // four adds, stray done in FETCH, start held while busy
    rom[0] = W_ADD0; rom[1] = W_ADD1; rom[2] = W_ADD2; rom[3] = W_ADD3; rom[4] = W_HALT;
    runs0 = run_total;
    stray_cyc = cyc + 1;
    pulse_start();
    wait_run(40);
    tick(2);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    wait_halted(80);
    chk("s3_count", 32'(instr_count),       32'd4);
    chk("s3_runs",  32'(run_total - runs0), 32'd4);
    chk("s3_pc",    32'(mem_addr),          32'd5);
    for (int i = 1; i < 4; i++) chk("s3_run_after_done", 32'(gap_log[runs0 + i]), 32'd3);
    stray_cyc = -1;
    tick(2);

    // done on the last permitted wait cycle wins over timeout
    dly = 16;
    rom[0] = W_ADD0; rom[1] = W_HALT;
    pulse_start();
    wait_halted(60);
    chk("s4_late_done_halted", 32'(halted),      32'd1);
    chk("s4_late_done_err",    32'(err),         32'd0);
    chk("s4_late_done_count",  32'(instr_count), 32'd1);
    tick(2);

    // done never arrives -> timeout
    dly = 0;
    pulse_start();
    n = 0;
    while (!err && n < 60) begin @(negedge clk); n++; end
    chk("s4_tmo_latency", 32'(cyc - st_cyc), 32'd20);
    chk("s4_tmo_busy",    32'(busy),         32'd0);
    tick(2);

    // restart from ERROR
    dly = 2;
    pulse_start();
    @(negedge clk);
    chk("s4_restart_err",  32'(err),      32'd0);
    chk("s4_restart_addr", 32'(mem_addr), 32'd0);
    chk("s4_restart_busy", 32'(busy),     32'd1);
    wait_halted(40);
    tick(2);

    // stop held: return to IDLE after first instruction
    stop = 1'b1; stop_lvl = 1'b1;
    rom[0] = W_ADD0; rom[1] = W_ADD1; rom[2] = W_HALT;
    pulse_start();
    wait_run(40);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("s5_stop_busy",   32'(busy),        32'd0);
    chk("s5_stop_halted", 32'(halted),      32'd0);
    chk("s5_stop_count",  32'(instr_count), 32'd1);
    chk("s5_stop_pc",     32'(mem_addr),    32'd1);
    tick(1);
    stop = 1'b0; stop_lvl = 1'b0;
    tick(2);

    // reset during WAIT_DONE, start held while busy beforehand
    dly = 0;
    rom[0] = W_ADD0;
    pulse_start();
    tick(8);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(1);
    do_reset();
    @(negedge clk);
    chk("s6_rst_busy",  32'(busy),        32'd0);
    chk("s6_rst_err",   32'(err),         32'd0);
    chk("s6_rst_run",   32'(proc_run),    32'd0);
    chk("s6_rst_din",   32'(proc_din),    32'd0);
    chk("s6_rst_addr",  32'(mem_addr),    32'd0);
    chk("s6_rst_count", 32'(instr_count), 32'd0);
    tick(3);
    dly = 2;

    // ADDR_W=2: mvi at address 3 takes its immediate from address 0
    rom2[0] = W_ADD0; rom2[1] = W_ADD1; rom2[2] = W_ADD2; rom2[3] = W_MVI;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    k = 0; n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (proc_run2) k++;
    end
    chk("s7_mvi_din", 32'(proc_din2),  32'(W_MVI));
    chk("s7_mvi_pc",  32'(mem_addr2),  32'd1);
    stop2 = 1'b1;
    @(negedge clk);
    chk("s7_imm_din", 32'(proc_din2),  32'(W_ADD0));
    n = 0;
    while (busy2 && n < 20) begin @(negedge clk); n++; end
    chk("s7_idle",    32'(busy2),        32'd0);
    chk("s7_pc",      32'(mem_addr2),    32'd1);
    chk("s7_count",   32'(instr_count2), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Fetch/issue sequencer that feeds the simple processor from a synchronous program ROM.
- Holds a program counter and fetches instruction words, plus the immediate word for mvi.
- Drives the processor's din and run inputs, then waits for its done before fetching the next instruction.
- Sits between the program memory and the processor top level; the processor's internal control FSM is unchanged.

Parameters:
ADDR_W, 8, program counter / ROM address width; PC wraps modulo 2^ADDR_W
TIMEOUT, 16, max cycles in WAIT_DONE before error; counter width clog2(TIMEOUT+1)
OP_MVI, 3'b001, opcode value (instr[8:6]) requiring an immediate word
OP_HALT, 3'b111, opcode value (instr[8:6]) that halts sequencing; never forwarded to processor

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse: begin execution at address 0
stop  input  1  level: stop after the current instruction completes
mem_addr  output  ADDR_W  ROM address (registered, equals pc)
mem_rdata  input  16  ROM data, valid one cycle after mem_addr
proc_din  output  16  to processor din
proc_run  output  1  to processor run, one-cycle pulse per instruction
proc_done  input  1  from processor done
busy  output  1  high in any state other than IDLE, HALTED, ERROR
halted  output  1  high in HALTED
err  output  1  high in ERROR (done timeout)
instr_count  output  16  completed instructions since start; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high), next edge: state=IDLE, pc=0, mem_addr=0, proc_din=0, proc_run=0, busy=0, halted=0, err=0, instr_count=0, instr_q=0, imm_q=0, timeout counter=0.
- Reset mid-operation aborts immediately; proc_run is never left high.
- mem_addr always equals pc.
- States:
  - IDLE: start=1 -> FETCH; pc=0, instr_count=0.
  - FETCH: ROM address presented -> LATCH.
  - LATCH: instr_q<=mem_rdata; pc<=pc+1. Next state by mem_rdata[8:6]:
    - OP_HALT -> HALTED.
    - OP_MVI -> IMM_FETCH.
    - else -> ISSUE.
  - IMM_FETCH -> IMM_LATCH.
  - IMM_LATCH: imm_q<=mem_rdata; pc<=pc+1 -> ISSUE.
  - ISSUE: proc_din=instr_q, proc_run=1 for exactly this cycle -> WAIT_DONE; timeout counter cleared.
  - WAIT_DONE: proc_run=0. proc_din=imm_q if instr_q[8:6]==OP_MVI, else instr_q. Counter increments each cycle.
    - proc_done=1: instr_count+1 (saturating). Then stop=1 -> IDLE, else -> FETCH.
    - Counter reaches TIMEOUT without done -> ERROR.
  - HALTED: halted=1. start=1 -> FETCH with pc=0, instr_count=0.
  - ERROR: err=1. start=1 -> FETCH with pc=0, instr_count=0; err clears.
- proc_din outside ISSUE/WAIT_DONE holds its last value (0 after reset).
- Latency, start sample to proc_run high:
  - 3 cycles for non-mvi (FETCH, LATCH, ISSUE).
  - 5 cycles for mvi.
  - After proc_done, next proc_run follows 3 (or 5) cycles later.
- Boundary conditions:
  - pc at 2^ADDR_W-1 increments to 0 silently, including between an mvi word and its immediate.
  - start while busy is ignored.
  - proc_done outside WAIT_DONE is ignored.
  - proc_done and timeout expiry in the same cycle: done wins.
  - stop sampled only on the done cycle.
  - The HALT word is consumed (pc advanced) but never issued; instr_count is not incremented for it.

Test Plan:
- ROM[0]=mv R1,R0 (opcode 000), ROM[1]=HALT; pulse start; processor asserts done 2 cycles after run -> proc_run high exactly once, 3 cycles after start, proc_din=ROM[0]; then halted=1, instr_count=1, pc=2.
- ROM[0]=mvi R2 (opcode 001), ROM[1]=16'h00A5, ROM[2]=HALT -> run at cycle 5 with proc_din=ROM[0]; proc_din=16'h00A5 from the following cycle until done; pc=3 at halt.
- Four add instructions then HALT, stop held 0 -> four run pulses; each run 3 cycles after the previous done; instr_count=4.
- proc_done never asserted, TIMEOUT=16 -> err=1 and busy=0 after 16 WAIT_DONE cycles; start -> err=0, fetch resumes at pc=0.
- ADDR_W=2, mvi at address 3 with immediate at address 0 -> immediate taken from ROM[0]; pc wraps to 1.
- reset asserted during WAIT_DONE, and start held high during busy -> after reset: all outputs 0, state IDLE. start while busy causes no restart; pc sequence unchanged.
